// File: rtl/seq_chunk_adder.sv
// ---- seq_chunk_adder : multi-cycle add/sub, CHUNK bits per clock, carry rippled through a register (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             overflow,
  output logic             busy,
  output logic             ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;

  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_result;

  // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
  assign w_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  generate
    if (N > 1) begin : g_acc
      logic [WIDTH-CHUNK-1:0] acc_q, acc_d;

      // Finished chunks enter at the top; after N-1 shifts chunk 0 sits at the bottom.
      assign w_result = {w_sum[CHUNK-1:0], acc_q};

      always_comb begin
        acc_d = acc_q;
        if (state_q == ST_RUN) begin
          acc_d = w_result[WIDTH-1:CHUNK];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end else begin : g_no_acc
      assign w_result = w_sum[CHUNK-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? ~c_in : c_in;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = w_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          s_d     = w_result;
          c_out_d = w_sum[CHUNK];
          // Carry into the MSB recovered from the MSB's own sum bit.
          ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  assign S        = s_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_RUN);
  assign ready    = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// ---- tb_seq_chunk_adder : vector table, handshake sequences and randomized parameter sweep (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit go      = 1'b0;

  logic        m_start, m_sub, m_cin;
  logic [15:0] m_a, m_b, m_s;
  logic        m_cout, m_ovf, m_busy, m_ready;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(m_start), .sub(m_sub), .c_in(m_cin),
    .A(m_a), .B(m_b), .S(m_s), .c_out(m_cout), .overflow(m_ovf),
    .busy(m_busy), .ready(m_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    case (i)
      0: return 1;
      1: return 16;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vt[10];

  // Starts one operation on the 16/4 instance, scrambles inputs after accept,
  // and checks that S holds its previous value until completion.
  task automatic run_main(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic c, input logic [15:0] hold_s, output int lat);
    m_a = a; m_b = b; m_sub = s; m_cin = c; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    m_a = 16'($urandom); m_b = 16'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
    chk("busy_after_accept", m_busy, 1);
    chk("ready_drop_on_accept", m_ready, 0);
    lat = 0;
    while (lat < 12) begin
      chk("s_hold_during_run", m_s, hold_s);
      @(posedge clk); #1;
      lat++;
      if (m_ready) break;
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int W  = cfg_w(gi);
      localparam int C  = cfg_c(gi);
      localparam int NN = W / C;

      logic         start, sub, cin, s_c, s_v, busy, ready;
      logic [W-1:0] a, b, s;
      bit           done = 1'b0;

      seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .c_in(cin),
        .A(a), .B(b), .S(s), .c_out(s_c), .overflow(s_v),
        .busy(busy), .ready(ready)
      );

      initial begin
        logic [W-1:0] ea, eb, exp_s;
        logic         esub, ecin, exp_c, exp_v;
        longint       ua, ub, sa, sb, ci, full, r, half;
        int           lat, sel;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        wait (go);
        @(posedge clk); #1;
        half = longint'(1) << (W - 1);
        for (int k = 0; k < 1000; k++) begin
          sel = $urandom_range(0, 3);
          ea  = (sel == 0) ? '1 : (sel == 1) ? {1'b0, {(W-1){1'b1}}} : W'($urandom);
          sel = $urandom_range(0, 3);
          eb  = (sel == 0) ? '1 : (sel == 1) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
          esub = 1'($urandom);
          ecin = 1'($urandom);

          // Reference: plain integer arithmetic on the operands' unsigned and signed values.
          ua = longint'(ea); ub = longint'(eb); ci = longint'(ecin);
          sa = (ua >= half) ? ua - 2 * half : ua;
          sb = (ub >= half) ? ub - 2 * half : ub;
          if (!esub) begin
            full  = ua + ub + ci;
            exp_c = full[W];
            r     = sa + sb + ci;
          end else begin
            full  = ua - ub - ci;
            exp_c = (full >= 0);
            r     = sa - sb - ci;
          end
          exp_s = full[W-1:0];
          exp_v = (r < -half) || (r > half - 1);

          a = ea; b = eb; sub = esub; cin = ecin; start = 1'b1;
          @(posedge clk); #1;
          chk("sweep_busy", busy, 1);
          chk("sweep_ready_low", ready, 0);
          lat = 0;
          while (lat < 2 * NN + 4) begin
            start = 1'($urandom);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (ready) break;
          end
          start = 1'b0;
          chk("sweep_latency", lat, NN);
          chk("sweep_s", s, exp_s);
          chk("sweep_c_out", s_c, exp_c);
          chk("sweep_overflow", s_v, exp_v);
        end
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    int          lat;
    logic [15:0] prev;
    logic        exp_rdy;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[8] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0};

    m_start = 1'b0; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
    #12;
    chk("reset_s", m_s, 0);
    chk("reset_c_out", m_cout, 0);
    chk("reset_overflow", m_ovf, 0);
    chk("reset_busy", m_busy, 0);
    chk("reset_ready", m_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    prev = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      run_main(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, prev, lat);
      chk("vec_latency", lat, 4);
      chk("vec_s", m_s, vt[i].s);
      chk("vec_c_out", m_cout, vt[i].c);
      chk("vec_overflow", m_ovf, vt[i].v);
      chk("vec_busy_done", m_busy, 0);
      @(posedge clk); #1;
      chk("vec_ready_held", m_ready, 1);
      prev = vt[i].s;
    end

    // start pulses on RUN cycles 1 and 2 with other operands must be ignored
    m_a = 16'h1234; m_b = 16'h4321; m_sub = 1'b0; m_cin = 1'b0; m_start = 1'b1;
    @(posedge clk); #1;
    m_a = 16'hFFFF; m_b = 16'hFFFF; m_sub = 1'b1; m_cin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_start = 1'b0;
    @(posedge clk); #1;
    chk("ignore_not_ready_early", m_ready, 0);
    @(posedge clk); #1;
    chk("ignore_ready", m_ready, 1);
    chk("ignore_s", m_s, 16'h5555);
    chk("ignore_c_out", m_cout, 0);
    @(posedge clk); #1;
    chk("ignore_no_restart", m_busy, 0);

    // start held high: results at edges 4 and 9 after the first accept
    m_a = 16'h0001; m_b = 16'h0001; m_sub = 1'b0; m_cin = 1'b0; m_start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      exp_rdy = (k == 4) || (k == 9);
      chk("b2b_ready", m_ready, exp_rdy);
      chk("b2b_busy", m_busy, !exp_rdy);
      if (exp_rdy) chk("b2b_s", m_s, 16'h0002);
    end
    m_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_third_ready", m_ready, 1);

    run_main(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h0002, lat);
    chk("pre_reset_s", m_s, 16'h7FFF);
    chk("pre_reset_c_out", m_cout, 1);
    chk("pre_reset_overflow", m_ovf, 1);

    // asynchronous reset between edges in the middle of an operation
    m_a = 16'h1111; m_b = 16'h2222; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s", m_s, 0);
    chk("async_rst_c_out", m_cout, 0);
    chk("async_rst_overflow", m_ovf, 0);
    chk("async_rst_busy", m_busy, 0);
    chk("async_rst_ready", m_ready, 0);
    #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_ready", m_ready, 0);
    chk("post_rst_busy", m_busy, 0);

    go = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(posedge clk);
    end
    chk("sweep_complete", {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, clocked, multi-cycle adder/subtractor.
- Processes CHUNK bits per cycle and ripples the carry between cycles through a register.
- Signals completion with a ready flag that falls when new operands are accepted and rises when the result is valid.
- Generalises the team's fixed 4-bit ripple adder with delay-based ready: width and chunk size are configurable, and completion is clock-exact, with handshake, busy, subtract mode and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- Derived, not a port: N = WIDTH/CHUNK, the number of cycles per operation.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled on rising clk.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- c_in  input  1  carry-in (add) or borrow-in (sub); latched with start.
- A  input  WIDTH  operand A; latched with start.
- B  input  WIDTH  operand B; latched with start.
- S  output  WIDTH  result.
- c_out  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- overflow  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.
- busy  output  1  operation in progress.
- ready  output  1  S, c_out and overflow are valid for the last accepted operation.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - S=0, c_out=0, overflow=0, busy=0, ready=0.
  - Chunk counter, operand and carry registers cleared.
  - The in-flight operation is discarded and never completes.
- States:
  - IDLE (busy=0): entered from reset or on completion.
  - RUN (busy=1).
- IDLE -> RUN: on a rising edge with start=1.
  - Latch A.
  - Latch B' = sub ? ~B : B.
  - Latch carry register = sub ? ~c_in : c_in.
  - counter=0, busy=1, ready=0.
  - ready drops at this edge even if it was 1 from a previous result.
- RUN, each rising edge:
  - Add chunk[counter] of A, chunk[counter] of B' and the carry register.
  - Store CHUNK sum bits into an internal accumulator at that chunk position.
  - Update the carry register; increment counter.
  - Chunk 0 is the LSBs.
- Completion, on the edge processing chunk N-1 (the N-th RUN edge):
  - S <= full accumulator including the final chunk.
  - c_out <= final carry; overflow <= carry into MSB XOR final carry.
  - busy=0, ready=1, state returns to IDLE.
- Latency: ready rises exactly N rising edges after the start-accept edge. For WIDTH=16, CHUNK=4 this is 4.
- Result hold:
  - S, c_out and overflow hold their previous values throughout RUN and change only at the completion edge.
  - ready stays 1 until the next accepted start or reset.
- start while busy=1: ignored. No re-latch and no effect on the in-flight operation.
- start on the completion edge: ignored, because busy is still 1 at that edge. It is accepted on the next edge if still asserted.
- start held high continuously: back-to-back operations.
  - Accept edge, N RUN edges, then re-accept on the edge after completion.
  - ready is high for exactly one cycle between operations.
- Input stability: A, B, sub and c_in may change freely after the accept edge.
- Arithmetic:
  - add: S = (A + B + c_in) mod 2^WIDTH.
  - sub: S = (A - B - c_in) mod 2^WIDTH, computed as A + ~B + ~c_in.
- Degenerate case CHUNK=WIDTH: N=1, and the result is ready one edge after accept.

Test Plan:
1. Reset: assert rst_n=0 mid-RUN, asynchronously between edges -> S, c_out, overflow, busy and ready all go to 0 immediately. After release, ready stays 0 until a new start.
2. Add, WIDTH=16, CHUNK=4: A=0x1234, B=0x4321, c_in=0, sub=0, start pulse -> busy=1 for 4 cycles; on the 4th edge ready=1, S=0x5555, c_out=0, overflow=0. S holds its old value during RUN.
3. Full carry ripple across chunks: A=0xFFFF, B=0x0001, c_in=0 -> S=0x0000, c_out=1, overflow=0. Signed overflow: A=0x7FFF, B=0x0001 -> S=0x8000, c_out=0, overflow=1.
4. Subtract with borrow: sub=1, A=0x0005, B=0x0007, c_in=0 -> S=0xFFFE, c_out=0, overflow=0. Borrow-in: sub=1, A=0x0010, B=0x0001, c_in=1 -> S=0x000E, c_out=1.
5. Handshake:
   - start pulses at cycles 1 and 2 of RUN with different operands -> ignored; the result matches the first operands.
   - start held high -> consecutive results with ready high for exactly 1 cycle between them.
6. Parameter sweep: instances with (WIDTH, CHUNK) = (8,1), (16,16) and (32,8). Random 1000 operations each, compared against a reference model -> latency is N and S/c_out/overflow match.
